// File: rtl/mcs8_bus_ctrl.sv
// MCS8 system-side bus controller: decodes T-states from the CPU, latches the
// 14-bit address and cycle type, and runs memory/IO transactions over req/ack.
module mcs8_bus_ctrl #(
  parameter int TIMEOUT     = 255,
  parameter int IO_IN_PORTS = 8
) (
  input  logic        CLK_I,
  input  logic        nRST_I,
  input  logic [2:0]  CPU_STATE_I,
  input  logic [7:0]  CPU_DAT_I,
  output logic [7:0]  CPU_DAT_O,
  output logic        CPU_DAT_OE_O,
  output logic        CPU_READY_O,
  output logic [13:0] ADDR_O,
  output logic [4:0]  PORT_O,
  output logic [7:0]  WDAT_O,
  output logic        MEM_REQ_O,
  output logic        IO_REQ_O,
  output logic        WE_O,
  input  logic        ACK_I,
  input  logic [7:0]  RDAT_I,
  output logic        ERR_O,
  output logic [1:0]  CYCLE_O
);
  typedef enum logic [2:0] {IDLE, ADR, RD_WAIT, RD_HOLD, WR_WAIT, WR_POST} state_t;

  localparam logic [2:0] ST_WAIT = 3'b000;
  localparam logic [2:0] ST_T1   = 3'b010;
  localparam logic [2:0] ST_T2   = 3'b100;
  localparam logic [2:0] ST_T3   = 3'b001;
  localparam logic [2:0] ST_T1I  = 3'b110;
  localparam logic [1:0] PCI     = 2'b00;
  localparam logic [1:0] PCC     = 2'b01;
  localparam logic [1:0] PCR     = 2'b10;

  state_t     state;
  logic [2:0] stReg, stPrev;
  logic [7:0] toCnt, t2Byte, t2Src;
  logic       entry, t1Ent, t2Ent, t3Ent, t3Exit;
  logic       gotT1, pendT2, reqAny, timeOut, done;

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      stReg  <= ST_WAIT;
      stPrev <= ST_WAIT;
    end else begin
      stReg  <= CPU_STATE_I;
      stPrev <= stReg;
    end
  end

  assign entry   = stReg != stPrev;
  assign t1Ent   = entry && (stReg == ST_T1 || stReg == ST_T1I);
  assign t2Ent   = entry && stReg == ST_T2;
  assign t3Ent   = entry && stReg == ST_T3;
  assign t3Exit  = entry && stPrev == ST_T3;
  // A T2 seen while a write was still posted is replayed from t2Byte.
  assign t2Src   = pendT2 ? t2Byte : CPU_DAT_I;
  assign reqAny  = MEM_REQ_O | IO_REQ_O;
  assign timeOut = reqAny && !ACK_I && toCnt == 8'(TIMEOUT - 1);
  assign done    = reqAny && (ACK_I || timeOut);

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      state        <= IDLE;
      CPU_DAT_O    <= '0;
      CPU_DAT_OE_O <= 1'b0;
      CPU_READY_O  <= 1'b1;
      ADDR_O       <= '0;
      PORT_O       <= '0;
      WDAT_O       <= '0;
      MEM_REQ_O    <= 1'b0;
      IO_REQ_O     <= 1'b0;
      WE_O         <= 1'b0;
      ERR_O        <= 1'b0;
      CYCLE_O      <= '0;
      toCnt        <= '0;
      t2Byte       <= '0;
      gotT1        <= 1'b0;
      pendT2       <= 1'b0;
    end else begin
      ERR_O <= timeOut;
      if (reqAny && !ACK_I) toCnt <= toCnt + 8'd1;
      case (state)
        IDLE: if (t1Ent) begin
          ADDR_O[7:0] <= CPU_DAT_I;
          state       <= ADR;
        end
        ADR: if (t2Ent || pendT2) begin
          pendT2       <= 1'b0;
          gotT1        <= 1'b0;
          CYCLE_O      <= t2Src[7:6];
          ADDR_O[13:8] <= t2Src[5:0];
          PORT_O       <= t2Src[5:1];
          toCnt        <= '0;
          case (t2Src[7:6])
            PCI, PCR: begin
              MEM_REQ_O   <= 1'b1;
              WE_O        <= 1'b0;
              CPU_READY_O <= 1'b0;
              state       <= RD_WAIT;
            end
            PCC: if (int'(t2Src[5:1]) < IO_IN_PORTS) begin
              IO_REQ_O    <= 1'b1;
              WE_O        <= 1'b0;
              CPU_READY_O <= 1'b0;
              state       <= RD_WAIT;
            end else begin
              // Output port: the accumulator travelled as the T1 byte.
              WDAT_O      <= ADDR_O[7:0];
              IO_REQ_O    <= 1'b1;
              WE_O        <= 1'b1;
              CPU_READY_O <= 1'b1;
              state       <= WR_POST;
            end
            default: begin
              CPU_READY_O <= 1'b1;
              state       <= WR_WAIT;
            end
          endcase
        end else if (t1Ent) begin
          ADDR_O[7:0] <= CPU_DAT_I;
        end
        RD_WAIT: if (done) begin
          CPU_DAT_O    <= ACK_I ? RDAT_I : 8'hFF;
          MEM_REQ_O    <= 1'b0;
          IO_REQ_O     <= 1'b0;
          CPU_READY_O  <= 1'b1;
          CPU_DAT_OE_O <= 1'b1;
          state        <= RD_HOLD;
        end
        RD_HOLD: begin
          if (t3Exit) CPU_DAT_OE_O <= 1'b0;
          if (t1Ent) begin
            CPU_DAT_OE_O <= 1'b0;
            ADDR_O[7:0]  <= CPU_DAT_I;
            state        <= ADR;
          end
        end
        WR_WAIT: if (t3Ent) begin
          WDAT_O    <= CPU_DAT_I;
          MEM_REQ_O <= 1'b1;
          WE_O      <= 1'b1;
          toCnt     <= '0;
          gotT1     <= 1'b0;
          state     <= WR_POST;
        end
        WR_POST: begin
          if (t1Ent) begin
            ADDR_O[7:0] <= CPU_DAT_I;
            gotT1       <= 1'b1;
          end
          if (t2Ent) begin
            t2Byte      <= CPU_DAT_I;
            pendT2      <= 1'b1;
            CPU_READY_O <= 1'b0;
          end
          if (done) begin
            MEM_REQ_O <= 1'b0;
            IO_REQ_O  <= 1'b0;
            WE_O      <= 1'b0;
            state     <= (gotT1 || t1Ent || pendT2 || t2Ent) ? ADR : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcs8_bus_ctrl.sv
// Directed bench for mcs8_bus_ctrl with TIMEOUT=4; expected values are hand-computed.
module tb_mcs8_bus_ctrl;
  localparam logic [2:0] T1 = 3'b010, T2 = 3'b100, T3 = 3'b001, T4 = 3'b111, WT = 3'b000;

  logic        CLK_I = 1'b0, nRST_I = 1'b0, ACK_I = 1'b0;
  logic [2:0]  CPU_STATE_I = WT;
  logic [7:0]  CPU_DAT_I = '0, RDAT_I = '0;
  logic [7:0]  CPU_DAT_O, WDAT_O;
  logic        CPU_DAT_OE_O, CPU_READY_O, MEM_REQ_O, IO_REQ_O, WE_O, ERR_O;
  logic [13:0] ADDR_O;
  logic [4:0]  PORT_O;
  logic [1:0]  CYCLE_O;
  int nChecks = 0, nErrors = 0;

  mcs8_bus_ctrl #(.TIMEOUT(4), .IO_IN_PORTS(8)) dut (
    .CLK_I(CLK_I), .nRST_I(nRST_I), .CPU_STATE_I(CPU_STATE_I), .CPU_DAT_I(CPU_DAT_I),
    .CPU_DAT_O(CPU_DAT_O), .CPU_DAT_OE_O(CPU_DAT_OE_O), .CPU_READY_O(CPU_READY_O),
    .ADDR_O(ADDR_O), .PORT_O(PORT_O), .WDAT_O(WDAT_O), .MEM_REQ_O(MEM_REQ_O),
    .IO_REQ_O(IO_REQ_O), .WE_O(WE_O), .ACK_I(ACK_I), .RDAT_I(RDAT_I),
    .ERR_O(ERR_O), .CYCLE_O(CYCLE_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // State is registered once, the entry action lands on the following edge.
  task automatic enter(input logic [2:0] st, input logic [7:0] d);
    CPU_STATE_I = st;
    CPU_DAT_I   = d;
    tick();
    tick();
  endtask

  task automatic ack(input logic [7:0] d);
    ACK_I  = 1'b1;
    RDAT_I = d;
    tick();
    ACK_I  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_ready", 16'(CPU_READY_O), 16'h1);
    chk("rst_req",   16'({MEM_REQ_O, IO_REQ_O, WE_O, ERR_O, CPU_DAT_OE_O}), 16'h0);
    chk("rst_addr",  16'(ADDR_O), 16'h0);
    nRST_I = 1'b1;
    tick();

    // PCI read, ACK on the third REQ clock
    enter(T1, 8'h34);
    enter(T2, 8'h12);
    chk("pci_addr",  16'(ADDR_O), 16'h1234);
    chk("pci_req0",  16'({MEM_REQ_O, WE_O, CPU_READY_O}), 16'b100);
    tick();
    chk("pci_req1",  16'(MEM_REQ_O), 16'h1);
    tick();
    chk("pci_req2",  16'({MEM_REQ_O, CPU_READY_O}), 16'b10);
    ack(8'h3E);
    chk("pci_done",  16'({MEM_REQ_O, CPU_READY_O, CPU_DAT_OE_O}), 16'b011);
    chk("pci_data",  16'(CPU_DAT_O), 16'h3E);
    enter(T3, 8'h00);
    chk("pci_oe_t3", 16'(CPU_DAT_OE_O), 16'h1);
    enter(T4, 8'h00);
    chk("pci_oe_t4", 16'(CPU_DAT_OE_O), 16'h0);

    // PCW write
    enter(T1, 8'hFF);
    enter(T2, 8'hFF);
    chk("pcw_addr",  16'(ADDR_O), 16'h3FFF);
    chk("pcw_cyc",   16'(CYCLE_O), 16'h3);
    chk("pcw_rdy2",  16'({CPU_READY_O, MEM_REQ_O}), 16'b10);
    enter(T3, 8'hA5);
    chk("pcw_req",   16'({MEM_REQ_O, WE_O, CPU_READY_O}), 16'b111);
    chk("pcw_wdat",  16'(WDAT_O), 16'hA5);
    ack(8'h00);
    chk("pcw_done",  16'({MEM_REQ_O, CPU_READY_O}), 16'b01);

    // PCC output to port 8
    enter(T1, 8'h5A);
    enter(T2, 8'h50);
    chk("pcco_req",  16'({IO_REQ_O, MEM_REQ_O, WE_O, CPU_READY_O}), 16'b1011);
    chk("pcco_port", 16'(PORT_O), 16'd8);
    chk("pcco_wdat", 16'(WDAT_O), 16'h5A);
    chk("pcco_cyc",  16'(CYCLE_O), 16'h1);
    ack(8'h00);
    chk("pcco_done", 16'(IO_REQ_O), 16'h0);

    // PCC input from port 3
    enter(T1, 8'h00);
    enter(T2, 8'h46);
    chk("pcci_req",  16'({IO_REQ_O, WE_O, CPU_READY_O}), 16'b100);
    chk("pcci_port", 16'(PORT_O), 16'd3);
    tick();
    chk("pcci_hold", 16'(CPU_READY_O), 16'h0);
    ack(8'h77);
    chk("pcci_done", 16'({IO_REQ_O, CPU_READY_O, CPU_DAT_OE_O}), 16'b011);
    chk("pcci_data", 16'(CPU_DAT_O), 16'h77);
    enter(T3, 8'h00);
    enter(T4, 8'h00);

    // Posted write still outstanding at the next T2; ACK lands on the timeout clock
    enter(T1, 8'h10);
    enter(T2, 8'hC0);
    enter(T3, 8'h3C);
    chk("post_req",  16'({MEM_REQ_O, WE_O}), 16'b11);
    CPU_STATE_I = T1; CPU_DAT_I = 8'h20;
    tick();
    CPU_STATE_I = T2;
    tick();
    CPU_DAT_I = 8'h00;
    tick();
    chk("post_rdy0", 16'({CPU_READY_O, MEM_REQ_O}), 16'b01);
    chk("post_lo",   16'(ADDR_O[7:0]), 16'h20);
    ack(8'h00);
    chk("post_ack",  16'({MEM_REQ_O, CPU_READY_O, ERR_O}), 16'b000);
    tick();
    chk("post_rd",   16'({MEM_REQ_O, WE_O, CPU_READY_O}), 16'b100);
    chk("post_addr", 16'(ADDR_O), 16'h0020);
    ack(8'h9C);
    chk("post_data", 16'({8'(CPU_READY_O), CPU_DAT_O}), 16'h019C);

    // Timeout on a PCR read
    enter(T3, 8'h00);
    enter(T4, 8'h00);
    enter(T1, 8'h55);
    enter(T2, 8'h81);
    chk("to_addr",   16'(ADDR_O), 16'h0155);
    tick();
    tick();
    tick();
    chk("to_req3",   16'({MEM_REQ_O, ERR_O}), 16'b10);
    tick();
    chk("to_drop",   16'({MEM_REQ_O, ERR_O, CPU_READY_O}), 16'b011);
    chk("to_data",   16'(CPU_DAT_O), 16'hFF);
    tick();
    chk("to_pulse",  16'(ERR_O), 16'h0);

    // ACK on the timeout clock wins
    enter(T3, 8'h00);
    enter(T4, 8'h00);
    enter(T1, 8'h66);
    enter(T2, 8'h00);
    tick();
    tick();
    tick();
    ack(8'h42);
    chk("tack_err",  16'({MEM_REQ_O, ERR_O}), 16'b00);
    chk("tack_data", 16'(CPU_DAT_O), 16'h42);

    // Reset during RD_WAIT, then a best-case read
    enter(T3, 8'h00);
    enter(T4, 8'h00);
    enter(T1, 8'h11);
    enter(T2, 8'h22);
    chk("rrst_pre",  16'(MEM_REQ_O), 16'h1);
    nRST_I = 1'b0;
    #1;
    chk("rrst_out",  16'({CPU_READY_O, MEM_REQ_O, CPU_DAT_OE_O}), 16'b100);
    chk("rrst_addr", 16'(ADDR_O), 16'h0);
    CPU_STATE_I = WT;
    tick();
    nRST_I = 1'b1;
    tick();
    enter(T1, 8'h34);
    enter(T2, 8'h12);
    chk("fast_req",  16'({MEM_REQ_O, CPU_READY_O}), 16'b10);
    ack(8'h3E);
    chk("fast_done", 16'({8'(CPU_READY_O), CPU_DAT_O}), 16'h013E);
    chk("fast_addr", 16'(ADDR_O), 16'h1234);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
